// File: rtl/ta_capture_pkg.sv
// Shared definitions for the traffic analyzer capture sequencer:
// state encoding, time-of-day widths and the start-time comparison.
package ta_capture_pkg;

    localparam int C_SEC_WIDTH  = 48;
    localparam int C_NSEC_WIDTH = 30;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_ALIGN   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    function automatic logic time_reached(
        input logic [C_SEC_WIDTH-1:0]  cur_sec,
        input logic [C_NSEC_WIDTH-1:0] cur_nsec,
        input logic [C_SEC_WIDTH-1:0]  tgt_sec,
        input logic [C_NSEC_WIDTH-1:0] tgt_nsec
    );
        return (cur_sec > tgt_sec) || ((cur_sec == tgt_sec) && (cur_nsec >= tgt_nsec));
    endfunction

endpackage

// File: rtl/ta_time_cmp.sv
// Registered start-time comparator: o_reached reflects the time inputs
// sampled at the previous clock edge.
module ta_time_cmp
    import ta_capture_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_resetn,
    input  logic [C_SEC_WIDTH-1:0]  i_sec,
    input  logic [C_NSEC_WIDTH-1:0] i_nsec,
    input  logic [C_SEC_WIDTH-1:0]  i_start_sec,
    input  logic [C_NSEC_WIDTH-1:0] i_start_nsec,
    output logic                    o_reached
);

    logic r_reached;

    // Register the comparison result so the start decision has no input-to-output path.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_reached <= 1'b0;
        end else begin
            r_reached <= time_reached(i_sec, i_nsec, i_start_sec, i_start_nsec);
        end
    end

    assign o_reached = r_reached;

endmodule

// File: rtl/traffic_analyzer_capture_ctrl.sv
// Capture sequencer: arms on software command, optionally waits for a PTP start
// time, opens/closes the capture window on frame boundaries and counts frames.
module traffic_analyzer_capture_ctrl
    import ta_capture_pkg::*;
#(
    parameter int C_FRAME_CNT_WIDTH = 32,
    parameter int C_TIMEOUT_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         gmii_en,
    input  logic [C_SEC_WIDTH-1:0]       sec,
    input  logic [C_NSEC_WIDTH-1:0]      nsec,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         start_at_en,
    input  logic [C_SEC_WIDTH-1:0]       start_sec,
    input  logic [C_NSEC_WIDTH-1:0]      start_nsec,
    input  logic [C_FRAME_CNT_WIDTH-1:0] frame_limit,
    input  logic [C_TIMEOUT_WIDTH-1:0]   timeout,
    output logic                         run,
    output logic                         freeze_stats,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic [C_FRAME_CNT_WIDTH-1:0] frames_captured,
    output logic [2:0]                   state_o
);

    state_t                         r_state, w_state_next;
    logic                           r_gmii_en_d;
    logic [C_FRAME_CNT_WIDTH-1:0]   r_frames, w_frames_next, w_frames_inc;
    logic [C_TIMEOUT_WIDTH-1:0]     r_tmo_cnt, w_tmo_next, w_tmo_inc;
    logic                           r_aborted, w_aborted_next;
    logic                           r_run, r_freeze, r_busy, r_done;
    logic                           w_reached, w_frame_end, w_tmo_hit, w_limit_hit;

    ta_time_cmp u_time_cmp (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_sec        (sec),
        .i_nsec       (nsec),
        .i_start_sec  (start_sec),
        .i_start_nsec (start_nsec),
        .o_reached    (w_reached)
    );

    // Both counters saturate; the timeout compares the post-increment value so
    // CAPTURE lasts exactly `timeout` cycles.
    assign w_frame_end  = r_gmii_en_d & ~gmii_en;
    assign w_frames_inc = (r_frames == '1) ? r_frames : r_frames + C_FRAME_CNT_WIDTH'(1'b1);
    assign w_tmo_inc    = (r_tmo_cnt == '1) ? r_tmo_cnt : r_tmo_cnt + C_TIMEOUT_WIDTH'(1'b1);
    assign w_tmo_hit    = (timeout != '0) && (w_tmo_inc == timeout);
    assign w_limit_hit  = (frame_limit != '0) && w_frame_end && (w_frames_inc == frame_limit);

    // Next-state, frame counter, timeout counter and abort flag.
    always_comb begin
        w_state_next   = r_state;
        w_frames_next  = r_frames;
        w_tmo_next     = r_tmo_cnt;
        w_aborted_next = r_aborted;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (arm && !abort) begin
                    w_state_next   = ST_ARMED;
                    w_frames_next  = '0;
                    w_tmo_next     = '0;
                    w_aborted_next = 1'b0;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    w_state_next   = ST_DONE;
                    w_aborted_next = 1'b1;
                end else if (!start_at_en || w_reached) begin
                    w_state_next = ST_ALIGN;
                end else begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ALIGN: begin
                if (abort) begin
                    w_state_next   = ST_DONE;
                    w_aborted_next = 1'b1;
                end else if (!gmii_en) begin
                    w_state_next = ST_CAPTURE;
                end else begin
                    w_state_next = ST_ALIGN;
                end
            end
            ST_CAPTURE: begin
                w_tmo_next = w_tmo_inc;
                if (w_frame_end) begin
                    w_frames_next = w_frames_inc;
                end else begin
                    w_frames_next = r_frames;
                end
                // A frame still on the wire is drained so the snapshot ends on a boundary.
                if (abort || w_tmo_hit) begin
                    w_state_next   = gmii_en ? ST_DRAIN : ST_DONE;
                    w_aborted_next = r_aborted | abort;
                end else if (w_limit_hit) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (w_frame_end) begin
                    w_frames_next = w_frames_inc;
                    w_state_next  = ST_DONE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and edge-detect history.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_gmii_en_d <= 1'b0;
            r_frames    <= '0;
            r_tmo_cnt   <= '0;
            r_aborted   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_gmii_en_d <= gmii_en;
            r_frames    <= w_frames_next;
            r_tmo_cnt   <= w_tmo_next;
            r_aborted   <= w_aborted_next;
        end
    end

    // Registered state decode; done marks the cycle freeze_stats rises.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_run    <= 1'b0;
            r_freeze <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_run    <= (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);
            r_freeze <= (r_state == ST_DONE);
            r_busy   <= (r_state == ST_ARMED) || (r_state == ST_ALIGN) ||
                        (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);
            r_done   <= (r_state == ST_DONE) && !r_freeze;
        end
    end

    assign run             = r_run;
    assign freeze_stats    = r_freeze;
    assign busy            = r_busy;
    assign done            = r_done;
    assign aborted         = r_aborted;
    assign frames_captured = r_frames;
    assign state_o         = r_state;

endmodule

// File: tb/tb_traffic_analyzer_capture_ctrl.sv
// Directed bench for the capture sequencer with hand-computed expectations.
module tb_traffic_analyzer_capture_ctrl;
    import ta_capture_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        gmii_en;
    logic [47:0] sec;
    logic [29:0] nsec;
    logic        arm;
    logic        abort;
    logic        start_at_en;
    logic [47:0] start_sec;
    logic [29:0] start_nsec;
    logic [31:0] frame_limit;
    logic [31:0] timeout;
    logic        run;
    logic        freeze_stats;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] frames_captured;
    logic [2:0]  state_o;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;

    traffic_analyzer_capture_ctrl #(
        .C_FRAME_CNT_WIDTH (32),
        .C_TIMEOUT_WIDTH   (32)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .gmii_en         (gmii_en),
        .sec             (sec),
        .nsec            (nsec),
        .arm             (arm),
        .abort           (abort),
        .start_at_en     (start_at_en),
        .start_sec       (start_sec),
        .start_nsec      (start_nsec),
        .frame_limit     (frame_limit),
        .timeout         (timeout),
        .run             (run),
        .freeze_stats    (freeze_stats),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .frames_captured (frames_captured),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic send_frame(input int len, input int gap);
        gmii_en = 1'b1;
        repeat (len) step();
        gmii_en = 1'b0;
        repeat (gap) step();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_run"},    64'(run),             64'd0);
        check_val({tag, "_freeze"}, 64'(freeze_stats),    64'd0);
        check_val({tag, "_busy"},   64'(busy),            64'd0);
        check_val({tag, "_done"},   64'(done),            64'd0);
        check_val({tag, "_abrt"},   64'(aborted),         64'd0);
        check_val({tag, "_frames"}, 64'(frames_captured), 64'd0);
        check_val({tag, "_state"},  64'(state_o),         64'(ST_IDLE));
    endtask

    initial begin
        resetn = 1'b1; gmii_en = 1'b0; sec = 48'd0; nsec = 30'd0;
        arm = 1'b0; abort = 1'b0; start_at_en = 1'b0;
        start_sec = 48'd0; start_nsec = 30'd0; frame_limit = 32'd0; timeout = 32'd0;
        #2 resetn = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        resetn = 1'b1;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("idle_abort_state", 64'(state_o), 64'(ST_IDLE));
        check_val("idle_abort_flag",  64'(aborted), 64'd0);

        // Immediate start, limit 3, five frames
        frame_limit = 32'd3;
        pulse_arm();
        check_val("t1_armed",     64'(state_o), 64'(ST_ARMED));
        check_val("t1_busy_lag",  64'(busy),    64'd0);
        step();
        check_val("t1_align",     64'(state_o), 64'(ST_ALIGN));
        check_val("t1_busy",      64'(busy),    64'd1);
        step();
        check_val("t1_capture",   64'(state_o), 64'(ST_CAPTURE));
        check_val("t1_run_lag",   64'(run),     64'd0);
        step();
        check_val("t1_run",       64'(run),     64'd1);
        send_frame(64, 12);
        check_val("t1_frames1",   64'(frames_captured), 64'd1);
        send_frame(64, 12);
        check_val("t1_frames2",   64'(frames_captured), 64'd2);
        gmii_en = 1'b1;
        repeat (64) step();
        gmii_en = 1'b0;
        step();
        check_val("t1_done_state", 64'(state_o),         64'(ST_DONE));
        check_val("t1_frames3",    64'(frames_captured), 64'd3);
        check_val("t1_done_early", 64'(done),            64'd0);
        check_val("t1_frz_early",  64'(freeze_stats),    64'd0);
        step();
        check_val("t1_done_pulse", 64'(done),            64'd1);
        check_val("t1_freeze",     64'(freeze_stats),    64'd1);
        check_val("t1_run_off",    64'(run),             64'd0);
        check_val("t1_busy_off",   64'(busy),            64'd0);
        step();
        check_val("t1_done_1cyc",  64'(done),            64'd0);
        check_val("t1_freeze_hold",64'(freeze_stats),    64'd1);
        repeat (9) step();
        send_frame(64, 12);
        send_frame(64, 12);
        check_val("t1_frames_hold", 64'(frames_captured), 64'd3);
        check_val("t1_state_hold",  64'(state_o),         64'(ST_DONE));
        check_val("t1_done_cnt",    64'(done_cnt),        64'd1);

        // Arm mid-frame: partial frame must not count
        frame_limit = 32'd0;
        gmii_en = 1'b1;
        repeat (10) step();
        pulse_arm();
        check_val("t2_armed",      64'(state_o),         64'(ST_ARMED));
        check_val("t2_cleared",    64'(frames_captured), 64'd0);
        step();
        check_val("t2_align",      64'(state_o),         64'(ST_ALIGN));
        check_val("t2_unfreeze",   64'(freeze_stats),    64'd0);
        repeat (20) step();
        check_val("t2_align_hold", 64'(state_o),         64'(ST_ALIGN));
        gmii_en = 1'b0;
        step();
        check_val("t2_capture",    64'(state_o),         64'(ST_CAPTURE));
        check_val("t2_no_partial", 64'(frames_captured), 64'd0);
        repeat (3) step();
        send_frame(20, 5);
        check_val("t2_frames1",    64'(frames_captured), 64'd1);

        // Abort during the second frame: drain, then done
        gmii_en = 1'b1;
        repeat (10) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("t4_drain",      64'(state_o),         64'(ST_DRAIN));
        check_val("t4_aborted",    64'(aborted),         64'd1);
        check_val("t4_run",        64'(run),             64'd1);
        repeat (5) step();
        check_val("t4_drain_hold", 64'(state_o),         64'(ST_DRAIN));
        gmii_en = 1'b0;
        step();
        check_val("t4_done",       64'(state_o),         64'(ST_DONE));
        check_val("t4_frames2",    64'(frames_captured), 64'd2);
        repeat (3) step();
        check_val("t4_done_cnt",   64'(done_cnt),        64'd2);

        // Scheduled start: sweep 9.999999990 s .. 10.000000600 s
        start_at_en = 1'b1;
        start_sec   = 48'd10;
        start_nsec  = 30'd500;
        sec         = 48'd9;
        nsec        = 30'd999999990;
        pulse_arm();
        check_val("t3_armed",      64'(state_o), 64'(ST_ARMED));
        check_val("t3_abrt_clr",   64'(aborted), 64'd0);
        for (int i = 1; i <= 7; i++) begin
            sec  = 48'd10;
            nsec = 30'(100 * (i - 1));
            step();
            check_val($sformatf("t3_sweep%0d", i), 64'(state_o),
                      (i == 7) ? 64'(ST_ALIGN) : 64'(ST_ARMED));
        end
        step();
        check_val("t3_capture",    64'(state_o), 64'(ST_CAPTURE));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("t3_abort_idle", 64'(state_o), 64'(ST_DONE));
        check_val("t3_aborted",    64'(aborted), 64'd1);

        // Timeout of 100 cycles on an idle line, then simultaneous arm+abort
        start_at_en = 1'b0;
        timeout     = 32'd100;
        pulse_arm();
        step();
        step();
        check_val("t5_capture",    64'(state_o), 64'(ST_CAPTURE));
        repeat (99) step();
        check_val("t5_before_to",  64'(state_o), 64'(ST_CAPTURE));
        step();
        check_val("t5_timeout",    64'(state_o), 64'(ST_DONE));
        check_val("t5_not_abrt",   64'(aborted), 64'd0);
        step();
        arm   = 1'b1;
        abort = 1'b1;
        step();
        arm   = 1'b0;
        abort = 1'b0;
        check_val("t5_both_state", 64'(state_o), 64'(ST_DONE));
        check_val("t5_both_abrt",  64'(aborted), 64'd0);
        step();
        check_val("t5_freeze",     64'(freeze_stats), 64'd1);
        check_val("t5_done_cnt",   64'(done_cnt),     64'd4);

        // Reset mid-capture with 7 frames counted
        timeout = 32'd0;
        pulse_arm();
        step();
        step();
        repeat (7) send_frame(8, 4);
        check_val("t6_frames7",    64'(frames_captured), 64'd7);
        pulse_arm();
        check_val("t6_arm_ignored",64'(state_o),         64'(ST_CAPTURE));
        check_val("t6_frames_kept",64'(frames_captured), 64'd7);
        gmii_en = 1'b1;
        repeat (3) step();
        #2 resetn = 1'b0;
        #1;
        check_all_zero("t6_async");
        repeat (3) step();
        check_val("t6_no_done",    64'(done_cnt), 64'd4);
        resetn  = 1'b1;
        gmii_en = 1'b0;
        step();
        check_val("t6_idle",       64'(state_o),  64'(ST_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_analyzer_capture_ctrl.md
# traffic_analyzer_capture_ctrl

Capture sequencer for the GMII traffic analyzer. It takes software arm/abort commands and an optional PTP start time, and drives the analyzer's `run` and `freeze_stats` controls so that a capture window starts and ends on frame boundaries. It counts the frames seen inside the window and reports completion, so software reads a consistent statistics/frame-buffer snapshot. It sits between the analyzer's CPU register block and the analyzer datapath, in the GMII `clk` domain.

## Interface
- `C_FRAME_CNT_WIDTH`, 32: width of the frame limit and frame counter.
- `C_TIMEOUT_WIDTH`, 32: width of the cycle timeout.
- `clk`  in  1: GMII-domain clock; the only clock.
- `resetn`  in  1: reset, asynchronous assert, active-low.
- `gmii_en`  in  1: GMII data-valid, monitored for frame boundaries.
- `sec`  in  48: time-of-day seconds.
- `nsec`  in  30: time-of-day nanoseconds.
- `arm`  in  1: single-cycle pulse that starts a capture sequence.
- `abort`  in  1: single-cycle pulse that ends the capture early.
- `start_at_en`  in  1: when 1, wait for the start time; when 0, start immediately.
- `start_sec`  in  48: start time, seconds; held stable while armed.
- `start_nsec`  in  30: start time, nanoseconds; held stable while armed.
- `frame_limit`  in  C_FRAME_CNT_WIDTH: frames to capture; 0 means unlimited.
- `timeout`  in  C_TIMEOUT_WIDTH: capture length cap in `clk` cycles; 0 means disabled.
- `run`  out  1: enable to the analyzer.
- `freeze_stats`  out  1: snapshot hold to the analyzer.
- `busy`  out  1: high in ARMED, ALIGN, CAPTURE and DRAIN.
- `done`  out  1: one-cycle pulse on entry to DONE.
- `aborted`  out  1: sticky; the last capture ended by abort.
- `frames_captured`  out  C_FRAME_CNT_WIDTH: frames completed inside the window; saturating.
- `state_o`  out  3: current state encoding, for the status register.

## Operation
- Frame start is `gmii_en` rising (compared with a registered copy). Frame end is `gmii_en` falling.
- States and transitions:
  - IDLE: on `arm`, go to ARMED; clear `frames_captured`, `aborted` and the timeout counter.
  - ARMED: go to ALIGN when `start_at_en` = 0, or when the time comparison is true. Time comparison: (`sec` > `start_sec`) or (`sec` == `start_sec` and `nsec` >= `start_nsec`), unsigned.
  - ALIGN: go to CAPTURE in the first cycle with `gmii_en` = 0, so that no partial frame is counted.
  - CAPTURE: increment `frames_captured` on each frame end. Increment the timeout counter every cycle.
    - Go to DONE when the count reaches a nonzero `frame_limit`. The frame end that reaches the limit moves to DONE in the same edge.
    - Go to DRAIN when a nonzero `timeout` expires or `abort` arrives, with `gmii_en` = 1.
    - Go to DONE when a nonzero `timeout` expires or `abort` arrives, with `gmii_en` = 0.
  - DRAIN: on frame end, count that frame and go to DONE.
  - DONE: on `arm`, go to ARMED (re-arm). Otherwise hold.
- `abort` in ARMED or ALIGN goes to DONE and sets `aborted`.
- `abort` in IDLE or DONE is ignored. `arm` in any state other than IDLE or DONE is ignored.
- `arm` and `abort` in the same cycle: abort wins, and `arm` is discarded.
- A frame end in the same cycle as a timeout or abort is counted, then the block goes to DONE.
- Outputs are decoded from the state:
  - `run` = 1 in CAPTURE and DRAIN.
  - `freeze_stats` = 1 in DONE, and 0 from ARMED onward after a re-arm.
- `frames_captured` saturates at all-ones. `frame_limit` is compared with ==.
- The timeout counter saturates and is compared with ==.

## Timing
- Every output is registered; no combinational path from input to output.
- Reset values: state IDLE; `run` 0, `freeze_stats` 0, `busy` 0, `done` 0, `aborted` 0, `frames_captured` 0, `state_o` 0.
- An `arm` sampled at edge N gives state ARMED after edge N. `busy` = 1 after edge N+1.
- `run` rises one cycle after the block enters CAPTURE.
- The time comparison uses registered `sec`/`nsec`, so the start decision lags the time input by 1 cycle.
- `done` is high for exactly one cycle, coincident with `freeze_stats` rising.
- Reset asserted mid-capture: all outputs return to their reset values asynchronously. No `done` is generated.

## Structure
- Package `ta_capture_pkg` holds:
  - the state encoding localparams: IDLE = 0, ARMED = 1, ALIGN = 2, CAPTURE = 3, DRAIN = 4, DONE = 5;
  - the time widths: 48-bit seconds, 30-bit nanoseconds.
- One sub-module, `ta_time_cmp`: a registered comparison of `sec`/`nsec` against `start_sec`/`start_nsec`, with a 1-cycle output `reached`.
- Everything else lives in one FSM and its counters.

## Test plan
- Immediate start, limit 3:
  - Stimulus: `arm` with `start_at_en` = 0, `frame_limit` = 3; five 64-byte frames separated by 12-cycle gaps.
  - Required: `frames_captured` = 3, then one `done` pulse; `freeze_stats` = 1 and `run` = 0 after the third frame end.
- Arm mid-frame:
  - Stimulus: `arm` while `gmii_en` = 1 in the middle of a frame.
  - Required: ALIGN holds until that frame ends; the partial frame is not counted.
- Scheduled start:
  - Stimulus: `start_sec` = 10, `start_nsec` = 500; `sec`/`nsec` sweep 9.999999990 s through 10.000000600 s.
  - Required: ARMED holds until `nsec` >= 500 with `sec` = 10; CAPTURE follows after alignment.
- Abort mid-frame:
  - Stimulus: `abort` in CAPTURE while `gmii_en` = 1 (second frame in progress).
  - Required: DRAIN, then DONE at that frame's end; `frames_captured` = 2; `aborted` = 1.
- Timeout and simultaneous events:
  - Stimulus: `timeout` = 100 with idle line; then `arm` and `abort` in the same cycle from DONE.
  - Required: DONE exactly 100 cycles into CAPTURE. For the simultaneous pulses: `arm` is discarded, state stays DONE and `aborted` is unchanged.
- Reset mid-capture:
  - Stimulus: assert `resetn` = 0 asynchronously in CAPTURE with `frames_captured` = 7.
  - Required: immediately all outputs 0 and state IDLE; no `done` pulse.
